branch_predict_fetch: RTL and testbench
=======================================

BRANCH_PREDICT_FETCH -- requirements
Module: branch_predict_fetch

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter BTB_ENTRIES, default 16, BTB depth; power of two, >=2; IDX = log2(BTB_ENTRIES).
REQ-003 Parameter CTR_BITS, default 2, saturating-counter width, >=1.
REQ-004 Parameter RESET_PC, default 0, pc_out value after reset.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold pc_out (load-use hazard).
REQ-008 ex_valid  in  1  EX-stage instruction is valid (not flushed).
REQ-009 ex_pc  in  XLEN  PC of the EX-stage instruction.
REQ-010 ex_is_branch  in  1  EX instruction is a conditional branch.
REQ-011 ex_is_jump  in  1  EX instruction is jal/jalr.
REQ-012 ex_taken  in  1  resolved direction; jumps are always taken.
REQ-013 ex_target  in  XLEN  resolved target.
REQ-014 ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
REQ-015 ex_pred_target  in  XLEN  predicted target carried down the pipe.
REQ-016 pc_out  out  XLEN  current fetch PC.
REQ-017 pred_taken  out  1  prediction for pc_out.
REQ-018 pred_target  out  XLEN  predicted target for pc_out.
REQ-019 redirect  out  1  mispredict; the core flushes IF_ID and ID_EX.
REQ-020 redirect_pc  out  XLEN  corrected fetch PC.

Function
REQ-021 BTB shall be direct-mapped; index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]; each entry holds valid, tag, target, jump flag and a CTR_BITS counter.
REQ-022 Lookup shall be combinational on pc_out: hit = valid && tag match; pred_taken = hit && (jump flag || counter MSB); pred_target = entry target when hit, else pc_out+4.
REQ-023 Mispredict shall be asserted when ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
REQ-024 A mispredict shall drive redirect=1 in the same cycle (combinational, 0-cycle latency).
REQ-025 redirect_pc shall be ex_target if ex_taken, else ex_pc+4.
REQ-026 A non-branch, non-jump instruction with ex_pred_taken=1 (alias) shall redirect to ex_pc+4 and clear that entry's valid bit.
REQ-027 Next-PC priority: rst -> RESET_PC; redirect -> redirect_pc; stall -> hold; pred_taken -> pred_target; else pc_out+4.
REQ-028 redirect shall override stall.
REQ-029 All PC arithmetic shall wrap modulo 2^XLEN, e.g. 0xFFFFFFFC+4 = 0x00000000.
REQ-030 Stored targets shall have bits[1:0] forced to 0.
REQ-031 Update shall occur on the clock edge for ex_valid branches and jumps only.
REQ-032 Miss + taken: allocate the entry; counter = 2^(CTR_BITS-1) (weakly taken) for branches, all-ones with jump flag set for jumps.
REQ-033 Miss + not-taken: no allocation.
REQ-034 Hit: counter +1 on taken (saturating at max) or -1 on not-taken (saturating at 0); target rewritten when taken.
REQ-035 A lookup and an update to the same index in the same cycle shall return the pre-update entry.
REQ-036 stall shall not block BTB updates.

Reset
REQ-037 While rst=1: pc_out=RESET_PC, all valid bits=0, statistics counters=0.
REQ-038 Outputs derived from reset state: pred_taken=0; redirect=0 unless EX inputs request one.
REQ-039 Reset mid-operation shall take effect in one cycle; ex_* inputs shall be ignored for update while rst=1.

Configuration
REQ-040 Macro BPF_STATS_EN defined: add outputs stat_branches (32, ex_valid branch/jump count) and stat_mispredicts (32, redirect count); both wrap at 2^32 and are cleared by rst.
REQ-041 Macro BPF_STATS_EN undefined: those ports and counters shall not exist; all other behaviour is identical.

Verification
REQ-042 Reset, then 3 free cycles -> pc_out 0, 4, 8, C; pred_taken=0 throughout.
REQ-043 Branch at 0x10 taken to 0x40, resolved with ex_pred_taken=0 -> redirect=1, redirect_pc=0x40, next pc_out=0x40; next fetch of 0x10 gives pred_taken=1, pred_target=0x40.
REQ-044 Same branch resolved not-taken twice with CTR_BITS=2 -> counter 2->1->0; third fetch gives pred_taken=0; each wrong prediction redirects to 0x14.
REQ-045 stall=1 together with a mispredict at 0x20 targeting 0x80 -> pc_out=0x80 next cycle; stall=1 alone -> pc_out held.
REQ-046 Alias: ex_is_branch=0, ex_is_jump=0, ex_pred_taken=1, ex_pc=0x30 -> redirect_pc=0x34 and entry invalidated; pc_out=0xFFFFFFFC with no hit -> wraps to 0.
REQ-047 rst asserted mid-run with populated BTB -> pc_out=RESET_PC next cycle; all lookups miss; with BPF_STATS_EN defined, stats read 0.

Source files
------------

// File: rtl/branch_predict_fetch.sv
// Fetch-PC generator with a direct-mapped BTB and per-entry saturating direction counters.
// Defining BPF_STATS_EN adds the stat_branches / stat_mispredicts counters and ports.
module branch_predict_fetch #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter int unsigned     CTR_BITS    = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_out,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
`ifdef BPF_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned         IDX      = $clog2(BTB_ENTRIES);
  localparam int unsigned         TAG_W    = XLEN - IDX - 2;
  localparam logic [XLEN-1:0]     PC_STEP  = XLEN'(4);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c,
                                                   input logic                up);
    if (up) begin
      return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    end
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [XLEN-1:0] align_tgt(input logic [XLEN-1:0] t);
    return {t[XLEN-1:2], 2'b00};
  endfunction

  // BTB storage: only the valid bits are reset, the payload is qualified by them
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [BTB_ENTRIES-1:0] jmp_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
  logic [CTR_BITS-1:0]    ctr_q [BTB_ENTRIES];

  logic [XLEN-1:0]        pc_q, pc_d;

  logic [IDX-1:0]         f_idx, ex_idx;
  logic [TAG_W-1:0]       f_tag, ex_tag;
  logic                   f_hit, ex_hit;
  logic                   ex_ctl, ex_upd_taken, mispredict;
  logic [XLEN-1:0]        seq_pc;

  logic                   ent_we;
  logic [XLEN-1:0]        ent_tgt_d;
  logic                   ent_jmp_d;
  logic [CTR_BITS-1:0]    ent_ctr_d;

  // Fetch-side lookup reads the registered BTB, so a same-cycle update is not visible
  assign f_idx       = pc_q[IDX+1:2];
  assign f_tag       = pc_q[XLEN-1:IDX+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign seq_pc      = pc_q + PC_STEP;
  assign pc_out      = pc_q;
  assign pred_taken  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][CTR_BITS-1]);
  assign pred_target = f_hit ? tgt_q[f_idx] : seq_pc;

  assign ex_idx       = ex_pc[IDX+1:2];
  assign ex_tag       = ex_pc[XLEN-1:IDX+2];
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctl       = ex_is_branch | ex_is_jump;
  assign ex_upd_taken = ex_taken | ex_is_jump;

  assign mispredict  = ex_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
  assign redirect    = mispredict;
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);

  always_comb begin
    valid_d   = valid_q;
    ent_we    = 1'b0;
    ent_tgt_d = tgt_q[ex_idx];
    ent_jmp_d = jmp_q[ex_idx];
    ent_ctr_d = ctr_q[ex_idx];
    if (rst) begin
      valid_d = '0;
    end else if (ex_valid && ex_ctl) begin
      if (ex_hit) begin
        ent_we    = 1'b1;
        ent_ctr_d = ctr_step(ctr_q[ex_idx], ex_upd_taken);
        if (ex_upd_taken) begin
          ent_tgt_d = align_tgt(ex_target);
          ent_jmp_d = ex_is_jump;
        end
      end else if (ex_upd_taken) begin
        ent_we           = 1'b1;
        valid_d[ex_idx]  = 1'b1;
        ent_tgt_d        = align_tgt(ex_target);
        ent_jmp_d        = ex_is_jump;
        ent_ctr_d        = ex_is_jump ? CTR_MAX : CTR_WEAK;
      end
    end else if (ex_valid && ex_pred_taken) begin
      // A predicted-taken non-control instruction means a stale alias: drop the entry
      valid_d[ex_idx] = 1'b0;
    end
  end

  always_comb begin
    pc_d = seq_pc;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
    if (ent_we) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ent_tgt_d;
      jmp_q[ex_idx] <= ent_jmp_d;
      ctr_q[ex_idx] <= ent_ctr_d;
    end
  end

`ifdef BPF_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q + {31'd0, ex_valid & ex_ctl};
    stat_mp_d = stat_mp_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Scoreboard bench for branch_predict_fetch: expectations are queued per cycle and drained against the outputs.
module tb_branch_predict_fetch;

  localparam int S_PC = 0, S_PT = 1, S_PTGT = 2, S_RED = 3, S_RPC = 4, S_STB = 5, S_STM = 6;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] pc_out, pred_target, redirect_pc;
  logic        pred_taken, redirect;
`ifdef BPF_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  string       exp_tag_q [$];
  int          exp_sig_q [$];
  logic [31:0] exp_val_q [$];

  branch_predict_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_out         (pc_out),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef BPF_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int s);
    case (s)
      S_PC:    return pc_out;
      S_PT:    return {31'd0, pred_taken};
      S_PTGT:  return pred_target;
      S_RED:   return {31'd0, redirect};
      S_RPC:   return redirect_pc;
`ifdef BPF_STATS_EN
      S_STB:   return stat_branches;
      S_STM:   return stat_mispredicts;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic sb_push(input string name, input int s, input logic [31:0] v);
    exp_tag_q.push_back($sformatf("c%0d_%s", cyc, name));
    exp_sig_q.push_back(s);
    exp_val_q.push_back(v);
  endtask

  task automatic sb_drain();
    string       t;
    int          s;
    logic [31:0] v;
    #2;
    while (exp_sig_q.size() > 0) begin
      t = exp_tag_q.pop_front();
      s = exp_sig_q.pop_front();
      v = exp_val_q.pop_front();
      check_eq(t, observe(s), v);
    end
  endtask

  task automatic exp_fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    sb_push("pc_out", S_PC, pc);
    sb_push("pred_taken", S_PT, {31'd0, pt});
    sb_push("pred_target", S_PTGT, ptgt);
  endtask

  task automatic exp_redir(input logic r, input logic [31:0] rpc);
    sb_push("redirect", S_RED, {31'd0, r});
    if (r) sb_push("redirect_pc", S_RPC, rpc);
  endtask

  task automatic ex_idle();
    ex_valid       = 1'b0;
    ex_pc          = 32'h0;
    ex_is_branch   = 1'b0;
    ex_is_jump     = 1'b0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  task automatic ex_set(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_is_branch   = br;
    ex_is_jump     = jmp;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic begin_cycle(input int c);
    @(negedge clk);
    cyc   = c;
    stall = 1'b0;
    ex_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    ex_idle();

    // Reset state and sequential fetch
    begin_cycle(0);  exp_fetch(32'h0, 1'b0, 32'h4);  exp_redir(1'b0, 32'h0); sb_drain();
    begin_cycle(1);  rst = 1'b0; exp_fetch(32'h0, 1'b0, 32'h4); sb_drain();
    begin_cycle(2);  exp_fetch(32'h4, 1'b0, 32'h8);  sb_drain();
    begin_cycle(3);  exp_fetch(32'h8, 1'b0, 32'hC);  sb_drain();
    begin_cycle(4);  exp_fetch(32'hC, 1'b0, 32'h10); sb_drain();

    // Branch 0x10 taken to 0x40, mispredicted; same-cycle lookup sees the old entry
    begin_cycle(5);  ex_set(32'h10, 1, 0, 1, 32'h40, 0, 32'h14);
    exp_fetch(32'h10, 1'b0, 32'h14); exp_redir(1'b1, 32'h40); sb_drain();
    begin_cycle(6);  ex_set(32'h0C, 1, 0, 0, 32'h50, 1, 32'h50);
    exp_fetch(32'h40, 1'b0, 32'h44); exp_redir(1'b1, 32'h10); sb_drain();

    // Counter walks 2 -> 1 -> 0 on not-taken resolutions
    begin_cycle(7);  ex_set(32'h10, 1, 0, 0, 32'h40, 1, 32'h40);
    exp_fetch(32'h10, 1'b1, 32'h40); exp_redir(1'b1, 32'h14); sb_drain();
    begin_cycle(8);  ex_set(32'h0C, 1, 0, 0, 32'h50, 1, 32'h50);
    exp_fetch(32'h14, 1'b0, 32'h18); exp_redir(1'b1, 32'h10); sb_drain();
    begin_cycle(9);  ex_set(32'h10, 1, 0, 0, 32'h40, 1, 32'h40);
    exp_fetch(32'h10, 1'b0, 32'h40); exp_redir(1'b1, 32'h14); sb_drain();
    begin_cycle(10); ex_set(32'h0C, 1, 0, 0, 32'h50, 1, 32'h50);
    exp_fetch(32'h14, 1'b0, 32'h18); exp_redir(1'b1, 32'h10); sb_drain();
    begin_cycle(11); ex_set(32'h10, 1, 0, 0, 32'h40, 0, 32'h14);
    exp_fetch(32'h10, 1'b0, 32'h40); exp_redir(1'b0, 32'h0); sb_drain();

    // Stall holds; redirect overrides stall
    begin_cycle(12); stall = 1'b1;
    exp_fetch(32'h14, 1'b0, 32'h18); exp_redir(1'b0, 32'h0); sb_drain();
    begin_cycle(13); stall = 1'b1; ex_set(32'h20, 1, 0, 1, 32'h80, 0, 32'h24);
    exp_fetch(32'h14, 1'b0, 32'h18); exp_redir(1'b1, 32'h80); sb_drain();

    // Jump allocation, then alias invalidation of that entry
    begin_cycle(14); ex_set(32'h30, 0, 1, 1, 32'h100, 0, 32'h34);
    exp_fetch(32'h80, 1'b0, 32'h84); exp_redir(1'b1, 32'h100); sb_drain();
    begin_cycle(15); ex_set(32'h2C, 1, 0, 0, 32'h44, 1, 32'h44);
    exp_fetch(32'h100, 1'b0, 32'h104); exp_redir(1'b1, 32'h30); sb_drain();
    begin_cycle(16); ex_set(32'h30, 0, 0, 0, 32'h0, 1, 32'h100);
    exp_fetch(32'h30, 1'b1, 32'h100); exp_redir(1'b1, 32'h34); sb_drain();
    begin_cycle(17); ex_set(32'h2C, 1, 0, 0, 32'h44, 1, 32'h44);
    exp_fetch(32'h34, 1'b0, 32'h38); exp_redir(1'b1, 32'h30); sb_drain();

    // Unaligned target is stored with low bits cleared; correct prediction still allocates
    begin_cycle(18); ex_set(32'h54, 1, 0, 1, 32'h203, 1, 32'h203);
    exp_fetch(32'h30, 1'b0, 32'h34); exp_redir(1'b0, 32'h0); sb_drain();
    begin_cycle(19); ex_set(32'h50, 1, 0, 0, 32'h99, 1, 32'h99);
    exp_fetch(32'h34, 1'b0, 32'h38); exp_redir(1'b1, 32'h54); sb_drain();
    begin_cycle(20);
    exp_fetch(32'h54, 1'b1, 32'h200); exp_redir(1'b0, 32'h0); sb_drain();

    // Target-only mispredict to the top of memory, then wrap to zero
    begin_cycle(21); ex_set(32'h200, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    exp_fetch(32'h200, 1'b0, 32'h204); exp_redir(1'b1, 32'hFFFF_FFFC); sb_drain();
    begin_cycle(22);
    exp_fetch(32'hFFFF_FFFC, 1'b0, 32'h0); sb_drain();

    // Reset mid-run: redirect still combinational, but PC and BTB reset
    begin_cycle(23); rst = 1'b1; ex_set(32'h54, 1, 0, 0, 32'h200, 1, 32'h200);
    exp_fetch(32'h0, 1'b0, 32'h4); exp_redir(1'b1, 32'h58); sb_drain();
    begin_cycle(24); rst = 1'b0; ex_set(32'h50, 1, 0, 0, 32'h99, 1, 32'h99);
    exp_fetch(32'h0, 1'b0, 32'h4); exp_redir(1'b1, 32'h54);
`ifdef BPF_STATS_EN
    sb_push("stat_branches", S_STB, 32'd0);
    sb_push("stat_mispredicts", S_STM, 32'd0);
`endif
    sb_drain();
    begin_cycle(25);
    exp_fetch(32'h54, 1'b0, 32'h58); exp_redir(1'b0, 32'h0);
`ifdef BPF_STATS_EN
    sb_push("stat_branches", S_STB, 32'd1);
    sb_push("stat_mispredicts", S_STM, 32'd1);
`endif
    sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
